encoder_peripheral: RTL and testbench
=====================================

ENCODER_PERIPHERAL -- requirements
Module: encoder_peripheral

Interface
REQ-001 SHALL have parameter none; all register addresses fixed as listed in Function.
REQ-002 clk_12MHz  in  1  sole clock; all state on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-004 databus  inout  32  driven only when select=1 and rw=1, else 'z.
REQ-005 reg_size  out(tri)  3  register byte count; driven only when select=1, else 'z.
REQ-006 register_addr  in  8  register select, stable before select rises.
REQ-007 rw  in  1  0=write, 1=read.
REQ-008 select  in  1  peripheral select from bus initiator.
REQ-009 encoder_la, encoder_lb, encoder_li  in  1 each  left quadrature A/B/index, asynchronous.
REQ-010 encoder_ra, encoder_rb, encoder_ri  in  1 each  right quadrature A/B/index, asynchronous.

Function
REQ-011 All six encoder inputs SHALL pass through 2-flop synchronizers; decode uses a third registered stage (prev state).
REQ-012 Each channel SHALL decode x4: Gray-code step 00->01->11->10->00 = +1, reverse = -1, no change = 0; CONTROL invert bit negates direction.
REQ-013 Both-bits-changed transition SHALL leave count unchanged and set the channel ERR status bit.
REQ-014 Counts SHALL be 32-bit two's complement, wrapping 0x7FFFFFFF->0x80000000 and 0x00000000->0xFFFFFFFF.
REQ-015 Registers: 0x00 COUNT_L (RW, size 4); 0x01 COUNT_R (RW, size 4); 0x02 STATUS (R/W1C, size 1: b0 ERR_L, b1 ERR_R, b2 IDX_L, b3 IDX_R); 0x03 CONTROL (RW, size 1: b0 INV_L, b1 INV_R, b2 IDX_CLR).
REQ-016 Unmapped address: read returns 0 with reg_size=0; write ignored.
REQ-017 Write SHALL occur once, on the first clk edge where select=1 and registered select=0 (rising edge) with rw=0, using databus low bytes per register size.
REQ-018 Read SHALL snapshot the addressed register on the select rising edge; databus valid no later than the following cycle and unchanged until select falls.
REQ-019 reg_size SHALL be combinationally valid whenever select=1, independent of rw.
REQ-020 Same-cycle COUNT write and count step: write value wins, step discarded.
REQ-021 Same-cycle STATUS W1C and new event on same bit: bit remains set.
REQ-022 select held high for multiple cycles SHALL produce exactly one write or one snapshot.
REQ-023 Both channels SHALL count independently and simultaneously with no lost steps at input rate up to clk/4.

Reset
REQ-024 On reset=0: counts 0, STATUS 0, CONTROL 0, synchronizers 0, select-edge register 0, databus and reg_size 'z.
REQ-025 Reset mid-transaction SHALL abort it; no partial write; after release, next select rising edge is a fresh transaction.
REQ-026 First decode after reset release SHALL not count (prev state loaded from synchronized inputs, not compared to 00).

Configuration
REQ-027 Macro ENCODER_INDEX_EN defined: rising edge of synchronized index sets IDX_x; if IDX_CLR=1, count cleared to 0 that cycle (index clear beats step, write beats index clear).
REQ-028 ENCODER_INDEX_EN undefined: index inputs ignored, STATUS b2/b3 and CONTROL b2 read 0 and are not writable; ports remain.

Verification
REQ-029 Left A/B sequence 00,01,11,10,00 x3 -> read 0x00 returns 0x0000000C, reg_size=4.
REQ-030 Write 0x00 with 0xFFFFFFFF, then one reverse step -> 0xFFFFFFFE; write 0x7FFFFFFF + one forward step -> 0x80000000.
REQ-031 Right A/B 00->11 -> COUNT_R unchanged, STATUS reads 0x02; write STATUS 0x02 -> reads 0x00.
REQ-032 Read 0x00 with select held 10 cycles while steps arrive -> databus constant at snapshot value; post-release read shows new count.
REQ-033 Read address 0x7F -> databus 0x00000000, reg_size 0; rw=0 with select=1 -> databus never driven.
REQ-034 ENCODER_INDEX_EN, CONTROL=0x04, count 0x00000123, index pulse -> COUNT_L 0, STATUS b2=1; reset pulse mid-write -> all registers 0.

Source files
------------

// File: rtl/encoder_peripheral.sv
// encoder_peripheral: dual x4 quadrature decoder with 32-bit position counts behind a select/rw register bus.
// Latency: an encoder edge reaches its count 3 clk_12MHz edges after it arrives; read data is valid the cycle after select rises.
// Backpressure: none; one access per select rising edge, and the initiator owns bus timing.
// Build option: define ENCODER_INDEX_EN to enable index capture (STATUS b2/b3) and index-clear of counts (CONTROL b2).
module encoder_peripheral (
    input  logic        clk_12MHz,
    input  logic        reset,
    inout  tri   [31:0] databus,
    output tri   [2:0]  reg_size,
    input  logic [7:0]  register_addr,
    input  logic        rw,
    input  logic        select,
    input  logic        encoder_la,
    input  logic        encoder_lb,
    input  logic        encoder_li,
    input  logic        encoder_ra,
    input  logic        encoder_rb,
    input  logic        encoder_ri
);

    localparam logic [7:0] ADDR_COUNT_L = 8'h00;
    localparam logic [7:0] ADDR_COUNT_R = 8'h01;
    localparam logic [7:0] ADDR_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_CONTROL = 8'h03;

`ifdef ENCODER_INDEX_EN
    localparam logic [3:0] STATUS_MASK  = 4'b1111;
    localparam logic [2:0] CONTROL_MASK = 3'b111;
`else
    localparam logic [3:0] STATUS_MASK  = 4'b0011;
    localparam logic [2:0] CONTROL_MASK = 3'b011;
`endif

    // Encoder bit order in the sync pipeline: {ri, rb, ra, li, lb, la}
    logic [5:0]  sync1, sync2, prev;
    logic [1:0]  prime_cnt;
    logic        decode_en;

    logic        sel_q;
    logic        sel_rise, wr_en, rd_en;
    logic [31:0] wr_dat;

    logic [31:0] count_l, count_r, count_l_nxt, count_r_nxt;
    logic [3:0]  status, status_nxt;
    logic [2:0]  control;
    logic [31:0] rd_dat, rd_mux;
    logic [2:0]  size_mux;

    logic [1:0]  chg_l, chg_r;
    logic        step_l, step_r, err_l, err_r, up_l, up_r;
    logic        idx_rise_l, idx_rise_r, idx_clr_l, idx_clr_r;
    logic        wr_count_l, wr_count_r, wr_status, wr_control;

    // Two-flop synchronizers plus a third "previous" stage for edge decode
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {encoder_ri, encoder_rb, encoder_ra, encoder_li, encoder_lb, encoder_la};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Hold off decoding until prev holds a real synchronized sample, so reset zeros never look like a step
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset)
            prime_cnt <= 2'd0;
        else if (prime_cnt != 2'd3)
            prime_cnt <= prime_cnt + 2'd1;
    end

    assign decode_en = (prime_cnt == 2'd3);

    // x4 decode: a single-bit change is a step whose direction is oldA ^ newB; a double change is an error
    assign chg_l  = {prev[0], prev[1]} ^ {sync2[0], sync2[1]};
    assign chg_r  = {prev[3], prev[4]} ^ {sync2[3], sync2[4]};
    assign step_l = decode_en & (^chg_l);
    assign step_r = decode_en & (^chg_r);
    assign err_l  = decode_en & (&chg_l);
    assign err_r  = decode_en & (&chg_r);
    assign up_l   = prev[0] ^ sync2[1] ^ control[0];
    assign up_r   = prev[3] ^ sync2[4] ^ control[1];

`ifdef ENCODER_INDEX_EN
    assign idx_rise_l = decode_en & sync2[2] & ~prev[2];
    assign idx_rise_r = decode_en & sync2[5] & ~prev[5];
`else
    logic unused_idx;
    assign unused_idx = ^{sync2[2], prev[2], sync2[5], prev[5]};
    assign idx_rise_l = 1'b0;
    assign idx_rise_r = 1'b0;
`endif
    assign idx_clr_l = idx_rise_l & control[2];
    assign idx_clr_r = idx_rise_r & control[2];

    // Select edge detector: exactly one access per select assertion
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset)
            sel_q <= 1'b0;
        else
            sel_q <= select;
    end

    assign sel_rise   = select & ~sel_q;
    assign wr_en      = sel_rise & ~rw;
    assign rd_en      = sel_rise & rw;
    assign wr_dat     = databus;
    assign wr_count_l = wr_en & (register_addr == ADDR_COUNT_L);
    assign wr_count_r = wr_en & (register_addr == ADDR_COUNT_R);
    assign wr_status  = wr_en & (register_addr == ADDR_STATUS);
    assign wr_control = wr_en & (register_addr == ADDR_CONTROL);

    // Count and status next-state: bus write beats index clear beats step; new events beat W1C
    always_comb begin
        count_l_nxt = count_l;
        count_r_nxt = count_r;
        if (wr_count_l)
            count_l_nxt = wr_dat;
        else if (idx_clr_l)
            count_l_nxt = '0;
        else if (step_l)
            count_l_nxt = up_l ? count_l + 32'd1 : count_l - 32'd1;
        if (wr_count_r)
            count_r_nxt = wr_dat;
        else if (idx_clr_r)
            count_r_nxt = '0;
        else if (step_r)
            count_r_nxt = up_r ? count_r + 32'd1 : count_r - 32'd1;
        status_nxt = status;
        if (wr_status)
            status_nxt = status & ~wr_dat[3:0];
        status_nxt = (status_nxt | {idx_rise_r, idx_rise_l, err_r, err_l}) & STATUS_MASK;
    end

    // Register file update
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            count_l <= '0;
            count_r <= '0;
            status  <= '0;
            control <= '0;
        end else begin
            count_l <= count_l_nxt;
            count_r <= count_r_nxt;
            status  <= status_nxt;
            if (wr_control)
                control <= wr_dat[2:0] & CONTROL_MASK;
        end
    end

    // Address decode for read data and byte count; unmapped reads as zero with size 0
    always_comb begin
        rd_mux   = '0;
        size_mux = 3'd0;
        case (register_addr)
            ADDR_COUNT_L: begin rd_mux = count_l;           size_mux = 3'd4; end
            ADDR_COUNT_R: begin rd_mux = count_r;           size_mux = 3'd4; end
            ADDR_STATUS:  begin rd_mux = {28'd0, status};   size_mux = 3'd1; end
            ADDR_CONTROL: begin rd_mux = {29'd0, control};  size_mux = 3'd1; end
            default:      begin rd_mux = '0;                size_mux = 3'd0; end
        endcase
    end

    // Read snapshot taken once on the select rising edge and held for the rest of the access
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset)
            rd_dat <= '0;
        else if (rd_en)
            rd_dat <= rd_mux;
    end

    assign databus  = (select && rw) ? rd_dat : 'z;
    assign reg_size = select ? size_mux : 'z;

endmodule

// File: tb/tb_encoder_peripheral.sv
`timescale 1ns/1ps
module tb_encoder_peripheral;

    logic        clk_12MHz = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  register_addr = 8'h00;
    logic        rw = 1'b0;
    logic        select = 1'b0;
    logic        encoder_la = 1'b0, encoder_lb = 1'b0, encoder_li = 1'b0;
    logic        encoder_ra = 1'b0, encoder_rb = 1'b0, encoder_ri = 1'b0;
    logic [31:0] tb_dat = 32'h0;
    logic        tb_drv = 1'b0;
    tri   [31:0] databus;
    tri   [2:0]  reg_size;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd_v;
    logic [2:0]  sz_v;
    logic [31:0] bus_w;
    logic [2:0]  sz_w;

`ifdef ENCODER_INDEX_EN
    localparam logic [31:0] CTRL_ALL = 32'h7;
`else
    localparam logic [31:0] CTRL_ALL = 32'h3;
`endif

    assign databus = tb_drv ? tb_dat : 'z;

    encoder_peripheral dut (
        .clk_12MHz    (clk_12MHz),
        .reset        (reset),
        .databus      (databus),
        .reg_size     (reg_size),
        .register_addr(register_addr),
        .rw           (rw),
        .select       (select),
        .encoder_la   (encoder_la),
        .encoder_lb   (encoder_lb),
        .encoder_li   (encoder_li),
        .encoder_ra   (encoder_ra),
        .encoder_rb   (encoder_rb),
        .encoder_ri   (encoder_ri)
    );

    always #42 clk_12MHz = ~clk_12MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_12MHz);
        #1;
    endtask

    // Set both channels' A/B ({A,B}) and hold for 4 cycles (clk/4 input rate)
    task automatic step_ab(input logic [1:0] l_ab, input logic [1:0] r_ab);
        encoder_la = l_ab[1]; encoder_lb = l_ab[0];
        encoder_ra = r_ab[1]; encoder_rb = r_ab[0];
        wait_cycles(4);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk_12MHz); #1;
        register_addr = a; rw = 1'b0; tb_dat = d; tb_drv = 1'b1; select = 1'b1;
        @(negedge clk_12MHz);
        bus_w = databus; sz_w = reg_size;
        @(posedge clk_12MHz); #1;
        select = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] sz);
        @(posedge clk_12MHz); #1;
        register_addr = a; rw = 1'b1; select = 1'b1;
        @(negedge clk_12MHz);
        sz = reg_size;
        @(posedge clk_12MHz);
        @(negedge clk_12MHz);
        d = databus;
        @(posedge clk_12MHz); #1;
        select = 1'b0; rw = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp_d, input logic [2:0] exp_sz);
        logic [31:0] d;
        logic [2:0]  sz;
        bus_read(a, d, sz);
        check({tag, "_dat"}, d, exp_d);
        check({tag, "_size"}, {29'd0, sz}, {29'd0, exp_sz});
    endtask

    initial begin
        // Reset with right channel parked at 01: first decode after release must not count
        encoder_ra = 1'b0; encoder_rb = 1'b1;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(6);
        check_reg("rst_count_l", 8'h00, 32'h0, 3'd4);
        check_reg("rst_count_r", 8'h01, 32'h0, 3'd4);
        check_reg("rst_status",  8'h02, 32'h0, 3'd1);
        check_reg("rst_control", 8'h03, 32'h0, 3'd1);

        // Right 01->00 is one reverse step
        step_ab(2'b00, 2'b00);
        check_reg("r_rev_step", 8'h01, 32'hFFFF_FFFF, 3'd4);

        // Right 00->11 is an illegal double change
        step_ab(2'b00, 2'b11);
        check_reg("r_err_count", 8'h01, 32'hFFFF_FFFF, 3'd4);
        check_reg("r_err_status", 8'h02, 32'h2, 3'd1);
        bus_write(8'h02, 32'h2);
        check_reg("w1c_status", 8'h02, 32'h0, 3'd1);

        // Left forward x3 full cycles while right runs reverse x3 simultaneously
        for (int i = 0; i < 3; i++) begin
            step_ab(2'b01, 2'b01);
            step_ab(2'b11, 2'b00);
            step_ab(2'b10, 2'b10);
            step_ab(2'b00, 2'b11);
        end
        check_reg("l_fwd12", 8'h00, 32'h0000_000C, 3'd4);
        check_reg("r_rev12", 8'h01, 32'hFFFF_FFF3, 3'd4);

        // Invert on left: a forward pattern counts down
        bus_write(8'h03, 32'h1);
        check_reg("ctrl_inv_l", 8'h03, 32'h1, 3'd1);
        step_ab(2'b01, 2'b11);
        check_reg("l_inv_step", 8'h00, 32'h0000_000B, 3'd4);
        bus_write(8'h03, 32'h0);
        step_ab(2'b00, 2'b11);
        check_reg("l_rev_step", 8'h00, 32'h0000_000A, 3'd4);

        // Wrap boundaries
        bus_write(8'h00, 32'hFFFF_FFFF);
        check_reg("l_wr_ff", 8'h00, 32'hFFFF_FFFF, 3'd4);
        step_ab(2'b10, 2'b11);
        check_reg("l_ff_rev", 8'h00, 32'hFFFF_FFFE, 3'd4);
        bus_write(8'h00, 32'h7FFF_FFFF);
        step_ab(2'b00, 2'b11);
        check_reg("l_maxpos_fwd", 8'h00, 32'h8000_0000, 3'd4);
        bus_write(8'h00, 32'h0);
        step_ab(2'b10, 2'b11);
        check_reg("l_zero_rev", 8'h00, 32'hFFFF_FFFF, 3'd4);

        // Write and forward step land on the same edge: write wins
        encoder_la = 1'b0; encoder_lb = 1'b0;
        @(posedge clk_12MHz);
        bus_write(8'h00, 32'h100);
        wait_cycles(4);
        check_reg("wr_beats_step", 8'h00, 32'h0000_0100, 3'd4);
        check_reg("no_err_l", 8'h02, 32'h0, 3'd1);

        // W1C and a new right error on the same edge: bit stays set
        step_ab(2'b00, 2'b00);
        check_reg("r_err2", 8'h02, 32'h2, 3'd1);
        encoder_ra = 1'b1; encoder_rb = 1'b1;
        @(posedge clk_12MHz);
        bus_write(8'h02, 32'h2);
        wait_cycles(4);
        check_reg("w1c_vs_event", 8'h02, 32'h2, 3'd1);
        bus_write(8'h02, 32'h2);
        check_reg("w1c_clear2", 8'h02, 32'h0, 3'd1);

        // Long read: snapshot holds while steps land underneath
        @(posedge clk_12MHz); #1;
        register_addr = 8'h00; rw = 1'b1; select = 1'b1;
        @(posedge clk_12MHz);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_12MHz);
            check("long_read_hold", databus, 32'h0000_0100);
            if (i == 1) begin encoder_la = 1'b0; encoder_lb = 1'b1; end
            if (i == 5) begin encoder_la = 1'b1; encoder_lb = 1'b1; end
        end
        @(posedge clk_12MHz); #1;
        select = 1'b0; rw = 1'b0;
        wait_cycles(4);
        check_reg("post_long_read", 8'h00, 32'h0000_0102, 3'd4);

        // Long write: only one write even with select held while a step arrives
        @(posedge clk_12MHz); #1;
        register_addr = 8'h01; rw = 1'b0; tb_dat = 32'h5; tb_drv = 1'b1; select = 1'b1;
        @(posedge clk_12MHz); #1;
        encoder_ra = 1'b1; encoder_rb = 1'b0;
        wait_cycles(6);
        select = 1'b0; tb_drv = 1'b0;
        wait_cycles(2);
        check_reg("single_write", 8'h01, 32'h0000_0006, 3'd4);

        // Unmapped write: DUT must not drive the bus while rw=0; write ignored
        bus_write(8'h7F, 32'h0);
        check("wr_bus_undriven", bus_w, 32'h0);
        check("wr_unmapped_size", {29'd0, sz_w}, 32'h0);
        bus_write(8'h02, 32'h0);
        check("wr_status_size", {29'd0, sz_w}, 32'h1);
        check_reg("unmapped_read", 8'h7F, 32'h0, 3'd0);
        check_reg("count_l_intact", 8'h00, 32'h0000_0102, 3'd4);
        check_reg("count_r_intact", 8'h01, 32'h0000_0006, 3'd4);

        // CONTROL writable bits
        bus_write(8'h03, 32'h7);
        check_reg("ctrl_mask", 8'h03, CTRL_ALL, 3'd1);
        bus_write(8'h03, 32'h0);

        // Index pulse with IDX_CLR set
        bus_write(8'h03, 32'h4);
        bus_write(8'h00, 32'h123);
        encoder_li = 1'b1;
        wait_cycles(4);
        encoder_li = 1'b0;
        wait_cycles(4);
`ifdef ENCODER_INDEX_EN
        check_reg("idx_clear", 8'h00, 32'h0, 3'd4);
        check_reg("idx_status", 8'h02, 32'h4, 3'd1);
`else
        check_reg("idx_ignored", 8'h00, 32'h0000_0123, 3'd4);
        check_reg("idx_status_0", 8'h02, 32'h0, 3'd1);
`endif

        // Reset in the middle of a write clears everything
        bus_write(8'h03, 32'h3);
        step_ab(2'b00, 2'b10);
        @(posedge clk_12MHz); #1;
        register_addr = 8'h00; rw = 1'b0; tb_dat = 32'hDEAD_BEEF; tb_drv = 1'b1; select = 1'b1;
        #10 reset = 1'b0;
        @(posedge clk_12MHz); #1;
        select = 1'b0; tb_drv = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(6);
        check_reg("mid_rst_count_l", 8'h00, 32'h0, 3'd4);
        check_reg("mid_rst_count_r", 8'h01, 32'h0, 3'd4);
        check_reg("mid_rst_status",  8'h02, 32'h0, 3'd1);
        check_reg("mid_rst_control", 8'h03, 32'h0, 3'd1);

        // Fresh transaction after reset works
        step_ab(2'b01, 2'b10);
        check_reg("post_rst_step", 8'h00, 32'h1, 3'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
